// File: rtl/machine_timer.sv
// Machine timer: 64-bit mtime with prescaled tick, 64-bit mtimecmp and a registered
// level interrupt, accessed through a single-cycle register strobe.
module machine_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        timer_int
);

  localparam logic [2:0] AddrMtimeLo = 3'd0;
  localparam logic [2:0] AddrMtimeHi = 3'd1;
  localparam logic [2:0] AddrCmpLo   = 3'd2;
  localparam logic [2:0] AddrCmpHi   = 3'd3;
  localparam logic [2:0] AddrCtrl    = 3'd4;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        timer_int_q, timer_int_d;

  logic [2:0]  word;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        unused_addr;

  assign word        = addr[4:2];
  assign wr_en       = sel & we;
  assign rd_en       = sel & ~we;
  assign tick        = en_q && (pcnt_q == prescale_q);
  assign unused_addr = ^addr[1:0];

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    prescale_d  = prescale_q;
    pcnt_d      = 8'd0;
    rdata_d     = rdata_q;
    rvalid_d    = rd_en;
    timer_int_d = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A software write to either mtime half replaces the whole increment for this edge.
    if (wr_en) begin
      case (word)
        AddrMtimeLo: mtime_d    = {mtime_q[63:32], wdata};
        AddrMtimeHi: mtime_d    = {wdata, mtime_q[31:0]};
        AddrCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
        AddrCmpHi:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        AddrCtrl: begin
          en_d       = wdata[0];
          prescale_d = wdata[15:8];
          pcnt_d     = 8'd0;
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      case (word)
        AddrMtimeLo: rdata_d = mtime_q[31:0];
        AddrMtimeHi: rdata_d = mtime_q[63:32];
        AddrCmpLo:   rdata_d = mtimecmp_q[31:0];
        AddrCmpHi:   rdata_d = mtimecmp_q[63:32];
        AddrCtrl:    rdata_d = {16'd0, prescale_q, 7'd0, en_q};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= {64{1'b1}};
      en_q        <= 1'b0;
      prescale_q  <= 8'd0;
      pcnt_q      <= 8'd0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      prescale_q  <= prescale_d;
      pcnt_q      <= pcnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign timer_int = timer_int_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: read results are scored against a queue of
// expected values pushed when each read is issued.
module tb_machine_timer;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        timer_int;

  int unsigned n_chk;
  int unsigned n_bad;
  int unsigned n_rd;
  int unsigned n_rvalid;
  logic [31:0] exp_q[$];

  machine_timer u_dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the access is taken on the following rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    exp_q.push_back(exp);
    n_rd++;
    @(negedge clk);
    sel = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      n_rvalid++;
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", 64'd1, 64'd0);
      end else begin
        chk("rdata", {32'd0, rdata}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_bad = 0; n_rd = 0; n_rvalid = 0;
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_int", {63'd0, timer_int}, 64'd0);
    reset = 1'b0;

    // Reset values, back-to-back, plus unmapped reads and an ignored unmapped write
    rd(5'h00, 32'h0);
    rd(5'h04, 32'h0);
    rd(5'h08, 32'hFFFF_FFFF);
    rd(5'h0C, 32'hFFFF_FFFF);
    rd(5'h10, 32'h0);
    rd(5'h14, 32'h0);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h1C, 32'h0);
    rd(5'h10, 32'h0);
    chk("int_after_rst", {63'd0, timer_int}, 64'd0);

    // PRESCALE=3: one tick every 4 cycles
    wr(5'h10, 32'h0000_0301);
    repeat (40) @(negedge clk);
    rd(5'h00, 32'd10);
    @(negedge clk);
    chk("rvalid_pulse", {63'd0, rvalid}, 64'd0);
    chk("rdata_hold", {32'd0, rdata}, 64'd10);

    // PRESCALE=0: one tick per cycle from a known value
    wr(5'h10, 32'h0);
    wr(5'h00, 32'h50);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h1);
    repeat (5) @(negedge clk);
    rd(5'h00, 32'h55);
    rd(5'h00, 32'h56);

    // Carry from bit 31 into bit 32
    wr(5'h10, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h10, 32'h1);
    rd(5'h00, 32'hFFFF_FFFE);
    rd(5'h00, 32'hFFFF_FFFF);
    rd(5'h00, 32'h0);
    rd(5'h04, 32'h1);

    // Full 64-bit wrap; all-ones also equals the reset mtimecmp
    wr(5'h10, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h10, 32'h1);
    chk("int_at_max", {63'd0, timer_int}, 64'd1);
    rd(5'h00, 32'hFFFF_FFFF);
    chk("int_at_max2", {63'd0, timer_int}, 64'd1);
    rd(5'h04, 32'h0);
    chk("int_after_wrap", {63'd0, timer_int}, 64'd0);
    rd(5'h00, 32'h1);

    // Interrupt rise one cycle after mtime reaches 0x20, fall one cycle after raise
    wr(5'h10, 32'h0);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'h20);
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h1);
    repeat (32) @(negedge clk);
    chk("int_before_cmp", {63'd0, timer_int}, 64'd0);
    @(negedge clk);
    chk("int_rise", {63'd0, timer_int}, 64'd1);
    wr(5'h08, 32'h1000);
    chk("int_at_write", {63'd0, timer_int}, 64'd1);
    @(negedge clk);
    chk("int_fall", {63'd0, timer_int}, 64'd0);

    // mtime write on a tick edge: write wins, counting resumes next edge
    wr(5'h00, 32'h100);
    rd(5'h00, 32'h100);
    rd(5'h00, 32'h101);
    rd(5'h04, 32'h0);

    // Reset mid-count with interrupt pending and a simultaneous write
    wr(5'h08, 32'h10);
    @(negedge clk);
    chk("int_pre_rst", {63'd0, timer_int}, 64'd1);
    reset = 1'b1;
    sel = 1'b1; we = 1'b1; addr = 5'h00; wdata = 32'h55;
    @(negedge clk);
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    chk("midrst_int", {63'd0, timer_int}, 64'd0);
    chk("midrst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("midrst_rdata", {32'd0, rdata}, 64'd0);
    rd(5'h00, 32'h0);
    rd(5'h10, 32'h0);
    rd(5'h0C, 32'hFFFF_FFFF);
    chk("int_post_rst", {63'd0, timer_int}, 64'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("rvalid_count", 64'(n_rvalid), 64'(n_rd));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sel  in  1  register access strobe, one cycle per access
- we  in  1  1 = write, 0 = read; qualified by sel
- addr  in  5  byte address; bits [1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, registered
- rvalid  out  1  read data valid, one-cycle pulse
- timer_int  out  1  machine timer interrupt pending, level, to CSR file timer_int input
REQ-003 The register map SHALL be:
- 0x00 MTIME_LO
- 0x04 MTIME_HI
- 0x08 MTIMECMP_LO
- 0x0C MTIMECMP_HI
- 0x10 CTRL: bit0 EN, bits[15:8] PRESCALE, other bits read 0

Function
REQ-004 mtime SHALL be a 64-bit unsigned counter; mtimecmp SHALL be a 64-bit register.
REQ-005 When EN=1, an internal 8-bit prescale counter SHALL increment each cycle. When the counter equals PRESCALE, it SHALL wrap to 0 and mtime SHALL increment by 1 on that edge (the tick).
- PRESCALE=0 gives one tick per cycle.
- PRESCALE=N gives one tick every N+1 cycles.
REQ-006 When EN=0, mtime SHALL hold and the prescale counter SHALL be held at 0.
REQ-007 Any CTRL write SHALL clear the prescale counter.
REQ-008 mtime increment SHALL carry from bit 31 into bit 32 within the same edge. 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 with no flag.
REQ-009 A write (sel=1, we=1) SHALL update the addressed 32-bit half on the next edge; the other half SHALL be unchanged.
REQ-010 If a write to MTIME_LO or MTIME_HI coincides with a tick, the write SHALL win and no increment SHALL be applied to either half that cycle. The prescale counter SHALL still advance.
REQ-011 A read (sel=1, we=0) SHALL drive rdata with the addressed register's pre-edge value on the next edge, with rvalid=1 for exactly one cycle.
- rdata SHALL hold its last value otherwise.
- Unmapped addresses SHALL read 0 with rvalid=1.
- Writes to unmapped addresses SHALL be ignored.
REQ-012 Back-to-back accesses on consecutive cycles SHALL each be serviced. There is no stall; the bus is always ready.
REQ-013 timer_int SHALL be registered: on each edge, timer_int <= (mtime >= mtimecmp), using 64-bit unsigned compare of pre-edge values.
- The compare SHALL be independent of EN.
- Latency from the compare becoming true to timer_int=1 SHALL be 1 cycle.
REQ-014 timer_int SHALL remain 1 while the condition holds. It SHALL deassert one cycle after software raises mtimecmp above mtime (or writes mtime below mtimecmp).
REQ-015 A half-write to mtimecmp that transiently makes mtime >= mtimecmp SHALL be allowed to assert timer_int. Software avoids this by writing MTIMECMP_HI=0xFFFF_FFFF first.

Reset
REQ-016 On reset the block SHALL set:
- mtime=0
- mtimecmp=0xFFFF_FFFF_FFFF_FFFF
- CTRL=0 (EN=0, PRESCALE=0)
- prescale counter=0
- rdata=0, rvalid=0, timer_int=0
REQ-017 Reset SHALL take priority over any simultaneous access or tick.
REQ-018 Reset asserted mid-count SHALL return all state to the REQ-016 values on that edge. No write pending at that edge SHALL take effect.

Verification
REQ-019 Reset, then read all five registers:
- MTIME_LO, MTIME_HI, CTRL SHALL read 0.
- MTIMECMP_LO and MTIMECMP_HI SHALL read 0xFFFFFFFF.
- rvalid SHALL pulse once per read.
- timer_int=0 throughout.
REQ-020 Write CTRL=0x0000_0301 (EN=1, PRESCALE=3), wait 40 cycles, then read MTIME_LO -> value SHALL be 10 (±1 for the write and read edges). With PRESCALE=0, mtime SHALL advance 1 per cycle.
REQ-021 Carry and wrap:
- Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE, EN=1, PRESCALE=0 -> after 2 ticks, HI=1 and LO=0.
- Load 0xFFFF_FFFF_FFFF_FFFF -> the next tick SHALL give mtime=0.
REQ-022 Interrupt timing:
- Set mtimecmp=0x0000_0000_0000_0020, EN=1, PRESCALE=0 from mtime=0 -> timer_int SHALL rise exactly 1 cycle after mtime reaches 0x20.
- Then write MTIMECMP_LO=0x1000 -> timer_int SHALL fall 1 cycle after the write edge.
REQ-023 Write collision: with EN=1 and PRESCALE=0, write MTIME_LO=0x100 on a tick cycle -> the next read SHALL return exactly 0x100 plus the ticks elapsed after the write edge, with no lost or doubled increment.
REQ-024 Reset mid-operation: assert reset for one cycle while EN=1 and timer_int=1 -> the next cycle SHALL show mtime=0, timer_int=0, and CTRL=0.
